meter_time_ctrl: RTL and testbench
==================================

# meter_time_ctrl

Timekeeping and needle-sequencing controller for the three-meter ammeter clock. It keeps hours, minutes and seconds from the system clock and accepts time-set requests over a valid/ready handshake. It drives the 8-bit `time_data` index (0..59) of each meter channel's LUT/PWM driver. Downward needle moves are slew-limited so meters never slam on wrap. An optional power-on full-scale sweep is included.

## Interface
Parameters:
- `SYSCLKHZ`, 50_000_000, system clock frequency in Hz
- `TICK_HZ`, 1, time-base tick rate; prescaler terminal count = SYSCLKHZ/TICK_HZ-1
- `SLEW_DIV`, 50_000, clock cycles per one-step needle decrement (≥2)

Ports:
- `clk`  in  1  system clock
- `Rst`  in  1  synchronous, active-high reset
- `En`  in  1  timekeeping enable; 0 freezes prescaler and counters
- `set_valid`  in  1  time-set request
- `set_ready`  out  1  controller accepts set this cycle
- `set_hour`  in  8  hour to load (0..11)
- `set_min`  in  8  minute to load (0..59)
- `set_sec`  in  8  second to load (0..59)
- `hour_data`  out  8  hour meter index 0..59
- `min_data`  out  8  minute meter index 0..59
- `sec_data`  out  8  second meter index 0..59
- `tick_o`  out  1  one-cycle pulse per time-base tick
- `busy`  out  1  self-test active or any channel slewing

## Operation
- States: `SWEEP_UP`, `SWEEP_DN`, `RUN`. The reset state is `SWEEP_UP` with SELFTEST_EN and `RUN` without it.
- `SWEEP_UP`: all three outputs step +1 every SLEW_DIV cycles from 0 to 59, then go to `SWEEP_DN`.
- `SWEEP_DN`: all three outputs step −1 from 59 to 0, then go to `RUN`.
- During the sweep, counters are held at 0, no ticks are generated and `set_ready`=0.
- `RUN` timekeeping:
  - The prescaler counts while `En`=1. At terminal count it wraps to 0 and `tick_o` pulses.
  - Each tick increments sec.
  - sec 59→0 carries to min.
  - min 59→0 carries to hour.
  - hour 11→0.
- Targets:
  - sec target = sec; min target = min.
  - hour target = hour*5 + min/12. This is integer-only: min/12 is a compare ladder with result 0..4, and hour*5 is computed as (hour<<2)+hour.
- Per-channel output rule:
  - target > output: output = target next cycle (jump up).
  - target < output: output decrements by 1 every SLEW_DIV cycles. The channel's slew counter restarts on the cycle the target first drops.
  - target == output: hold, slew counter cleared.
- `busy` = (state≠`RUN`) or any channel output≠target.
- `set_ready` = (state==`RUN`) and not `busy`.
- A set handshake completes when `set_valid` and `set_ready` are both 1. On handshake:
  - Counters load the clamped values: sec/min >59 → 59, hour >11 → 11.
  - The prescaler clears to 0.
- Set and tick in the same cycle: set wins and the tick increment is discarded (`tick_o` still pulses).
- `En`=0 does not stop slewing, and a set is still accepted.
- `Rst` mid-operation (including mid-sweep or mid-slew): all state returns to reset values on the next edge.

## Timing
- Reset values:
  - `hour_data`/`min_data`/`sec_data`=0, `tick_o`=0, counters=0, prescaler=0.
  - `busy`=1 and `set_ready`=0 with SELFTEST_EN.
  - `busy`=0 and `set_ready`=1 without it.
- Counters update on the same edge that registers `tick_o`=1.
- Outputs follow a counter change upward with 1-cycle latency.
- A first decrement occurs SLEW_DIV cycles after the target drops. A 59→0 slew takes 59*SLEW_DIV cycles.
- Self-test duration is 118*SLEW_DIV cycles from reset release to `RUN`.
- Set-loaded values appear on the outputs 2 cycles after handshake when moving up.

## Configuration
- `METER_SELFTEST_EN` defined: the power-on `SWEEP_UP`/`SWEEP_DN` sequence is compiled in, and reset enters `SWEEP_UP`.
- Not defined: sweep states and logic are absent, and reset enters `RUN` directly with outputs at 0.

## Test plan
Bench parameters: SYSCLKHZ=100, TICK_HZ=1, SLEW_DIV=4.
- Self-test (macro on): release `Rst`.
  - `sec_data` ramps 0→59 in 4-cycle steps, then back to 0.
  - `set_ready` rises 472 cycles after release. All three outputs are identical throughout.
- Wrap slew: set 3:59:58, then wait 2 ticks.
  - `hour_data` goes 19→20 in 1 cycle.
  - `sec_data` and `min_data` slew 59→0 over 236 cycles, with `busy`=1 throughout and `set_ready`=0.
- Clamp: set hour=14, min=75, sec=200 → `hour_data`=59, `min_data`=59, `sec_data`=59.
- Handshake:
  - `set_valid` held during a slew is not accepted until `busy` falls; it completes the cycle `set_ready`=1.
  - A set coincident with a tick loads the exact set values, and the next tick arrives 100 cycles later.
- Enable/hour wrap:
  - `En`=0 for 500 cycles: no `tick_o`, values unchanged.
  - Then 11:59:59 plus 1 tick → `hour_data` slews 59→0.
- Reset mid-slew: assert `Rst` during a sec 59→0 slew → all outputs read 0 the next cycle.

Source files
------------

// File: rtl/meter_time_ctrl.sv
// Timekeeping and slew-limited needle sequencing for the three-meter ammeter clock.
// Define METER_SELFTEST_EN to compile in the power-on full-scale sweep.
module meter_time_ctrl #(
  parameter int unsigned SYSCLKHZ = 50_000_000,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned SLEW_DIV = 50_000
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       En,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic [7:0] hour_data,
  output logic [7:0] min_data,
  output logic [7:0] sec_data,
  output logic       tick_o,
  output logic       busy
);

  localparam int unsigned   PRESC_TC   = SYSCLKHZ / TICK_HZ - 1;
  localparam int            PW         = (PRESC_TC > 0) ? $clog2(PRESC_TC + 1) : 1;
  localparam int            SW         = $clog2(SLEW_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_TC);
  localparam logic [SW-1:0] SLEW_LAST  = SW'(SLEW_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [7:0]    out_q  [3];
  logic [7:0]    out_d  [3];
  logic [SW-1:0] slew_q [3];
  logic [SW-1:0] slew_d [3];
  logic [7:0]    tgt_s  [3];
  logic [2:0]    min_div12_s;
  logic          run_s, tick_s, hs_s, tick_q, mismatch_s;

  function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

`ifdef METER_SELFTEST_EN
  localparam logic [1:0] SWEEP_UP = 2'd0;
  localparam logic [1:0] SWEEP_DN = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sweep_q, sweep_d;
  logic          sweep_step_s;

  assign run_s        = (state_q == RUN);
  assign sweep_step_s = !run_s && (sweep_q == SLEW_LAST);

  // Sweep sequencing: turn around at full scale, hand over to RUN back at zero.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (!run_s) begin
      sweep_d = sweep_step_s ? '0 : sweep_q + SW'(1);
      if (sweep_step_s && (state_q == SWEEP_UP) && (out_q[0] == 8'd58)) begin
        state_d = SWEEP_DN;
      end else if (sweep_step_s && (state_q == SWEEP_DN) && (out_q[0] == 8'd1)) begin
        state_d = RUN;
      end else begin
        state_d = state_q;
      end
    end else begin
      sweep_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= SWEEP_UP;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end
`else
  assign run_s = 1'b1;
`endif

  assign tick_s = run_s && En && (presc_q == PRESC_LAST);
  assign hs_s   = set_valid && set_ready;

  // A completed set overrides a coincident tick increment.
  always_comb begin
    presc_d = presc_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (hs_s) begin
      presc_d = '0;
    end else if (run_s && En) begin
      presc_d = tick_s ? '0 : presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end
    if (hs_s) begin
      hour_d = clamp8(set_hour, 8'd11);
      min_d  = clamp8(set_min, 8'd59);
      sec_d  = clamp8(set_sec, 8'd59);
    end else if (tick_s) begin
      if (sec_q == 8'd59) begin
        sec_d = 8'd0;
        if (min_q == 8'd59) begin
          min_d  = 8'd0;
          hour_d = (hour_q == 8'd11) ? 8'd0 : hour_q + 8'd1;
        end else begin
          min_d = min_q + 8'd1;
        end
      end else begin
        sec_d = sec_q + 8'd1;
      end
    end else begin
      sec_d = sec_q;
    end
  end

  always_comb begin
    if (min_q >= 8'd48)      min_div12_s = 3'd4;
    else if (min_q >= 8'd36) min_div12_s = 3'd3;
    else if (min_q >= 8'd24) min_div12_s = 3'd2;
    else if (min_q >= 8'd12) min_div12_s = 3'd1;
    else                     min_div12_s = 3'd0;
  end

  assign tgt_s[0] = sec_q;
  assign tgt_s[1] = min_q;
  assign tgt_s[2] = (hour_q << 2) + hour_q + {5'd0, min_div12_s};

  // Needles jump up at once but walk down one index per SLEW_DIV cycles.
  always_comb begin
    out_d  = out_q;
    slew_d = slew_q;
    for (int i = 0; i < 3; i++) begin
      if (run_s) begin
        if (tgt_s[i] > out_q[i]) begin
          out_d[i]  = tgt_s[i];
          slew_d[i] = '0;
        end else if (tgt_s[i] < out_q[i]) begin
          if (slew_q[i] == SLEW_LAST) begin
            out_d[i]  = out_q[i] - 8'd1;
            slew_d[i] = '0;
          end else begin
            slew_d[i] = slew_q[i] + SW'(1);
          end
        end else begin
          slew_d[i] = '0;
        end
      end
`ifdef METER_SELFTEST_EN
      else if (sweep_step_s) begin
        out_d[i] = (state_q == SWEEP_UP) ? out_q[i] + 8'd1 : out_q[i] - 8'd1;
      end
`endif
      else begin
        out_d[i] = out_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      presc_q <= '0;
      hour_q  <= 8'd0;
      min_q   <= 8'd0;
      sec_q   <= 8'd0;
      tick_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        out_q[i]  <= 8'd0;
        slew_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_s;
      for (int i = 0; i < 3; i++) begin
        out_q[i]  <= out_d[i];
        slew_q[i] <= slew_d[i];
      end
    end
  end

  assign mismatch_s = (out_q[0] != tgt_s[0]) || (out_q[1] != tgt_s[1]) || (out_q[2] != tgt_s[2]);
  assign busy       = !run_s || mismatch_s;
  assign set_ready  = run_s && !mismatch_s;
  assign tick_o     = tick_q;
  assign sec_data   = out_q[0];
  assign min_data   = out_q[1];
  assign hour_data  = out_q[2];

endmodule

// File: tb/tb_meter_time_ctrl.sv
// Scoreboard bench for meter_time_ctrl: a time-in-seconds reference model predicts every
// cycle's outputs, directed scenarios check the headline timings, then random sets/enables.
module tb_meter_time_ctrl;

  localparam int SYSCLKHZ = 100;
  localparam int TICK_HZ  = 1;
  localparam int SLEW_DIV = 4;
  localparam int TC       = SYSCLKHZ / TICK_HZ - 1;
`ifdef METER_SELFTEST_EN
  localparam bit SELFTEST = 1'b1;
`else
  localparam bit SELFTEST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic       En = 1'b1;
  logic       set_valid = 1'b0;
  logic [7:0] set_hour = 8'd0, set_min = 8'd0, set_sec = 8'd0;
  logic       set_ready, tick_o, busy;
  logic [7:0] hour_data, min_data, sec_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int h;
    int m;
    int s;
    bit tk;
    bit bz;
    bit rd;
  } exp_t;
  exp_t exp_q[$];

  meter_time_ctrl #(.SYSCLKHZ(SYSCLKHZ), .TICK_HZ(TICK_HZ), .SLEW_DIV(SLEW_DIV)) dut (
    .clk(clk), .Rst(Rst), .En(En),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .hour_data(hour_data), .min_data(min_data), .sec_data(sec_data),
    .tick_o(tick_o), .busy(busy)
  );

  always #5 clk = ~clk;

  // Meter index a channel should point at for a time of day held as seconds since 0:00:00.
  function automatic int tgt_of(input int t, input int ch);
    int sec, mn, hr;
    sec = t % 60;
    mn  = (t / 60) % 60;
    hr  = t / 3600;
    case (ch)
      0:       return sec;
      1:       return mn;
      default: return hr * 5 + mn / 12;
    endcase
  endfunction

  function automatic int clampc(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: one expectation per clock edge, from elapsed time and clock-of-day rules.
  initial begin : model
    bit run, tick, hs, ready, bz;
    int e, p, t, n, v;
    int out[3];
    bit sl[3];
    int se[3];
    int sv[3];
    int tg[3];
    exp_t x;
    run = 1'b0; ready = 1'b0; e = 0; p = 0; t = 0; n = 0; tick = 1'b0;
    for (int i = 0; i < 3; i++) begin out[i] = 0; sl[i] = 1'b0; se[i] = 0; sv[i] = 0; end
    forever begin
      @(posedge clk);
      n++;
      if (Rst) begin
        run = !SELFTEST; e = 0; p = 0; t = 0; tick = 1'b0;
        for (int i = 0; i < 3; i++) begin out[i] = 0; sl[i] = 1'b0; end
      end else if (!run) begin
        e++;
        tick = 1'b0;
        if (e >= 118 * SLEW_DIV) begin run = 1'b1; v = 0; end
        else if (e < 59 * SLEW_DIV) v = e / SLEW_DIV;
        else v = 118 - e / SLEW_DIV;
        for (int i = 0; i < 3; i++) out[i] = v;
      end else begin
        for (int i = 0; i < 3; i++) tg[i] = tgt_of(t, i);
        hs   = set_valid && ready;
        tick = En && (p == TC);
        if (hs) p = 0;
        else if (En) p = tick ? 0 : p + 1;
        if (hs) t = clampc(int'(set_hour), 11) * 3600 + clampc(int'(set_min), 59) * 60
                    + clampc(int'(set_sec), 59);
        else if (tick) t = (t + 1) % 43200;
        for (int i = 0; i < 3; i++) begin
          if (tg[i] > out[i]) begin
            out[i] = tg[i]; sl[i] = 1'b0;
          end else if (tg[i] < out[i]) begin
            if (!sl[i]) begin sl[i] = 1'b1; se[i] = n; sv[i] = out[i]; end
            out[i] = sv[i] - (n - se[i] + 1) / SLEW_DIV;
          end else begin
            sl[i] = 1'b0;
          end
        end
      end
      bz = !run;
      for (int i = 0; i < 3; i++) if (out[i] != tgt_of(t, i)) bz = 1'b1;
      ready = run && !bz;
      x.h = out[2]; x.m = out[1]; x.s = out[0]; x.tk = tick; x.bz = bz; x.rd = ready;
      exp_q.push_back(x);
    end
  end

  // Monitor: compare what the DUT shows after each edge against the queued expectation.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (hour_data !== 8'(x.h) || min_data !== 8'(x.m) || sec_data !== 8'(x.s) ||
            tick_o !== x.tk || busy !== x.bz || set_ready !== x.rd) begin
          errors++;
          $display("FAIL scoreboard @%0t: got h=%0d m=%0d s=%0d tick=%0b busy=%0b ready=%0b, expected h=%0d m=%0d s=%0d tick=%0b busy=%0b ready=%0b",
                   $time, hour_data, min_data, sec_data, tick_o, busy, set_ready,
                   x.h, x.m, x.s, x.tk, x.bz, x.rd);
        end
      end
    end
  end

  initial begin : watchdog
    #(900_000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic do_set(input int h, input int m, input int s);
    int k;
    @(negedge clk);
    set_hour = 8'(h); set_min = 8'(m); set_sec = 8'(s);
    set_valid = 1'b1;
    k = 0;
    while (set_ready !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    chk("set_accept", set_ready, 1);
    @(posedge clk);
    #1;
    set_valid = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (tick_o !== 1'b1 && n < limit);
    chk("tick_wait", tick_o, 1);
  endtask

  initial begin : stim
    int n, cyc;
    bit bad;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hour", hour_data, 0);
    chk("reset_tick", tick_o, 0);
    @(negedge clk);
    Rst = 1'b0;
`ifdef METER_SELFTEST_EN
    cyc = 0;
    while (set_ready !== 1'b1 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    chk("selftest_len", cyc, 472);
`else
    #1;
    chk("ready_after_reset", set_ready, 1);
`endif

    // Wrap slew: 3:59:58 plus two ticks
    do_set(3, 59, 58);
    wait_tick(150, n);
    chk("tick_period_after_set", n, 100);
    wait_tick(150, n);
    En = 1'b0;
    @(posedge clk); #1;
    chk("hour_jump_20", hour_data, 20);
    chk("min_slew_start", min_data, 59);
    set_hour = 8'd14; set_min = 8'd75; set_sec = 8'd200;
    set_valid = 1'b1;
    cyc = 1; bad = 1'b0;
    while (sec_data != 8'd0 && cyc < 400) begin
      if (busy !== 1'b1 || set_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    chk("sec_slew_len", cyc, 236);
    chk("busy_during_slew", bad, 0);
    chk("min_slew_done", min_data, 0);
    chk("ready_after_slew", set_ready, 1);
    @(posedge clk); #1;
    set_valid = 1'b0;
    @(posedge clk); #1;
    chk("clamp_hour", hour_data, 59);
    chk("clamp_min", min_data, 59);
    chk("clamp_sec", sec_data, 59);

    // Enable low freezes time; then 11:59:59 wraps the hour needle
    bad = 1'b0;
    repeat (500) begin
      @(posedge clk); #1;
      if (tick_o !== 1'b0 || hour_data != 8'd59 || sec_data != 8'd59) bad = 1'b1;
    end
    chk("en_low_frozen", bad, 0);
    En = 1'b1;
    wait_tick(200, n);
    chk("tick_after_enable", n, 100);
    @(posedge clk); #1;
    chk("hour_slew_start", hour_data, 59);
    cyc = 1;
    while (hour_data != 8'd0 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    chk("hour_slew_len", cyc, 236);

    // Set coincident with a tick
    wait_tick(300, n);
    repeat (99) @(posedge clk);
    #1;
    set_hour = 8'd6; set_min = 8'd30; set_sec = 8'd45;
    set_valid = 1'b1;
    @(posedge clk); #1;
    set_valid = 1'b0;
    chk("tick_with_set", tick_o, 1);
    @(posedge clk); #1;
    chk("coinc_hour", hour_data, 32);
    chk("coinc_min", min_data, 30);
    chk("coinc_sec", sec_data, 45);
    cyc = 1;
    while (tick_o !== 1'b1 && cyc < 300) begin @(posedge clk); #1; cyc++; end
    chk("tick_after_coinc_set", cyc, 100);

    // Reset in the middle of a second-needle slew
    do_set(6, 30, 59);
    wait_tick(150, n);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_before_reset", busy, 1);
    @(negedge clk);
    Rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_hour", hour_data, 0);
    chk("rst_min", min_data, 0);
    chk("rst_sec", sec_data, 0);
    @(negedge clk);
    Rst = 1'b0;

    // Randomized sets and enable toggling, checked by the scoreboard
    for (int it = 0; it < 24; it++) begin
      @(negedge clk);
      En = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0:       do_set(int'($urandom_range(0, 11)), int'($urandom_range(0, 59)),
                          int'($urandom_range(0, 59)));
          1:       do_set(int'($urandom_range(0, 20)), int'($urandom_range(50, 80)),
                          int'($urandom_range(55, 255)));
          default: do_set(11, 59, int'($urandom_range(56, 59)));
        endcase
      end
      repeat ($urandom_range(1, 300)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
